// File: rtl/dither_readout_tx_pkg.sv
// Shared types and sizing for the pixel-link readout path.
package dither_readout_tx_pkg;

    localparam int IMAGEX_DEF       = 64;
    localparam int IMAGEY_DEF       = 64;
    localparam int RGB_SIZE         = 8;
    localparam int SRAM_ADDR_WIDTH  = 16;
    localparam int PIXELS_PER_BYTE  = 8;
    localparam int THRESH_BIT       = RGB_SIZE - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } rd_state_t;

    // Pixel is white iff >= 128, which is exactly its MSB.
    function automatic logic pixel_to_bit(input logic [RGB_SIZE-1:0] pix);
        return pix[THRESH_BIT];
    endfunction

endpackage

// File: rtl/dither_readout_tx_if.sv
// SRAM read port and byte stream handshake of the readout transmitter.
interface dither_readout_tx_if;

    logic [dither_readout_tx_pkg::SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic                                              sram_rden;
    logic [dither_readout_tx_pkg::RGB_SIZE-1:0]        sram_q;
    logic [7:0]                                        tx_data;
    logic                                              tx_valid;
    logic                                              tx_ready;

    modport master (
        output sram_addr, sram_rden, tx_data, tx_valid,
        input  sram_q, tx_ready
    );

    modport slave (
        input  sram_addr, sram_rden, tx_data, tx_valid,
        output sram_q, tx_ready
    );

endinterface

// File: rtl/dither_readout_tx_packer.sv
// Collects thresholded pixel bits MSB-first; presents the completed byte on the 8th bit.
module dither_readout_tx_packer
    import dither_readout_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift,
    input  logic       bit_in,
    output logic [7:0] next_byte,
    output logic       last_bit
);

    // Only the previous seven bits are stored; the eighth arrives live with the byte load.
    logic [PIXELS_PER_BYTE-2:0] shreg;
    logic [2:0]                 bit_cnt;

    assign next_byte = {shreg, bit_in};
    assign last_bit  = (bit_cnt == 3'(PIXELS_PER_BYTE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift) begin
            shreg   <= next_byte[PIXELS_PER_BYTE-2:0];
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/dither_readout_tx.sv
// Reads the dithered image in raster order, packs 1-bit pixels into bytes and streams them out.
module dither_readout_tx
    import dither_readout_tx_pkg::*;
#(
    parameter int IMAGEX = IMAGEX_DEF,
    parameter int IMAGEY = IMAGEY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    dither_readout_tx_if.master bus,
    output logic                busy,
    output logic                done
);

    localparam int IMAGE_SIZE       = IMAGEX * IMAGEY;
    localparam int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_IDX = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

    rd_state_t                   state;
    logic [IMAGE_ADDR_WIDTH-1:0] pix_idx;
    logic                        last_byte;
    logic                        pack_clear;
    logic                        pack_shift;
    logic                        pack_last;
    logic [7:0]                  pack_byte;

    assign pack_clear = (state == ST_IDLE) && start;
    assign pack_shift = (state == ST_CAPTURE);

    dither_readout_tx_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clear),
        .shift     (pack_shift),
        .bit_in    (pixel_to_bit(bus.sram_q)),
        .next_byte (pack_byte),
        .last_bit  (pack_last)
    );

    // pix_idx wraps to zero after the final pixel for power-of-two images, so
    // end-of-image is remembered in last_byte rather than derived from pix_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            pix_idx       <= '0;
            last_byte     <= 1'b0;
            bus.sram_addr <= '0;
            bus.sram_rden <= 1'b0;
            bus.tx_data   <= '0;
            bus.tx_valid  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pix_idx       <= '0;
                        last_byte     <= 1'b0;
                        bus.sram_addr <= '0;
                        bus.sram_rden <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    bus.sram_rden <= 1'b0;
                    state         <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    pix_idx <= pix_idx + 1'b1;
                    if (pack_last) begin
                        bus.tx_data  <= pack_byte;
                        bus.tx_valid <= 1'b1;
                        last_byte    <= (pix_idx == LAST_IDX);
                        state        <= ST_SEND;
                    end else begin
                        bus.sram_addr <= SRAM_ADDR_WIDTH'(pix_idx + 1'b1);
                        bus.sram_rden <= 1'b1;
                        state         <= ST_FETCH;
                    end
                end
                ST_SEND: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        if (last_byte) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            bus.sram_addr <= SRAM_ADDR_WIDTH'(pix_idx);
                            bus.sram_rden <= 1'b1;
                            state         <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    bus.sram_rden <= 1'b0;
                    bus.tx_valid  <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dither_readout_tx.sv
// Directed bench for dither_readout_tx: SRAM model, negedge monitor, one task per scenario.
module tb_dither_readout_tx;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    dither_readout_tx_if bus ();

    dither_readout_tx dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:4095];
    always @(posedge clk) if (bus.sram_rden) bus.sram_q <= mem[bus.sram_addr[11:0]];

    int checks = 0;
    int errors = 0;

    bit rand_en = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_en) bus.tx_ready = 1'($urandom_range(0, 1));
    end

    int cyc, hs_count, rd_count, rden_double, addr_oob, byte_bad, stall_viol, stall_seen;
    int done_count, hs_last_cyc, done_cyc, busy_fall_cyc, first_addr;
    int hits [0:4095];
    logic [7:0] exp_byte, prev_data, first_byte;
    logic prev_valid, prev_ready, prev_rden, prev_busy;

    task automatic clear_mon();
        hs_count = 0; rd_count = 0; rden_double = 0; addr_oob = 0; byte_bad = 0;
        stall_viol = 0; stall_seen = 0; done_count = 0; hs_last_cyc = -1; done_cyc = -1;
        busy_fall_cyc = -1; first_addr = -1; first_byte = 8'h00;
        for (int i = 0; i < 4096; i++) hits[i] = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (bus.tx_valid && bus.tx_ready) begin
            if (hs_count == 0) first_byte = bus.tx_data;
            if (bus.tx_data !== exp_byte) byte_bad++;
            hs_count++;
            hs_last_cyc = cyc;
        end
        if (prev_valid && !prev_ready) begin
            stall_seen++;
            if (!bus.tx_valid || bus.tx_data !== prev_data) stall_viol++;
        end
        if (bus.sram_rden) begin
            rd_count++;
            if (first_addr < 0) first_addr = int'(bus.sram_addr);
            if (bus.sram_addr >= 16'd4096) addr_oob++;
            else hits[bus.sram_addr[11:0]]++;
            if (prev_rden) rden_double++;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_valid = bus.tx_valid;
        prev_ready = bus.tx_ready;
        prev_data  = bus.tx_data;
        prev_rden  = bus.sram_rden;
        prev_busy  = busy;
    end

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives a one-cycle start and counts edges from the sampling edge to tx_valid.
    task automatic do_start(output int lat);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        while (!bus.tx_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        ok = done;
    endtask

    task automatic load_first_pattern();
        logic [7:0] pat [0:7];
        pat = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'hC0, 8'h3F, 8'hFF, 8'h00};
        for (int i = 0; i < 4096; i++) mem[i] = (i < 8) ? pat[i] : 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++; if (bus.sram_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h expected 0000", bus.sram_addr); end
        checks++; if (bus.sram_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b expected 0", bus.sram_rden); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h expected 00", bus.tx_data); end
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b expected 0", bus.tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_first_byte();
        int lat;
        load_first_pattern();
        bus.tx_ready = 1'b1;
        clear_mon();
        do_start(lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL first_latency got %0d expected 16", lat); end
        // FF 00 80 7F C0 3F FF 00 -> MSBs 1,0,1,0,1,0,1,0
        checks++; if (bus.tx_data !== 8'hAA) begin errors++; $display("FAIL first_byte got %h expected aa", bus.tx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b expected 1", busy); end
        checks++; if (rd_count !== 8) begin errors++; $display("FAIL first_reads got %0d expected 8", rd_count); end
        do_reset();
    endtask

    task automatic test_full_image();
        int lat; bit ok; int bad_hits;
        for (int i = 0; i < 4096; i++) mem[i] = 8'hFF;
        bus.tx_ready = 1'b1;
        exp_byte = 8'hFF;
        clear_mon();
        do_start(lat);
        wait_done(20000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_done_timeout got %b expected 1", ok); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_width got %b expected 0", done); end
        repeat (3) @(posedge clk);
        checks++; if (hs_count !== 512) begin errors++; $display("FAIL full_bytes got %0d expected 512", hs_count); end
        checks++; if (byte_bad !== 0) begin errors++; $display("FAIL full_data bad bytes %0d expected 0", byte_bad); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL full_done_count got %0d expected 1", done_count); end
        checks++; if (done_cyc !== hs_last_cyc + 1) begin errors++; $display("FAIL full_done_timing got %0d expected %0d", done_cyc, hs_last_cyc + 1); end
        checks++; if (busy_fall_cyc !== done_cyc + 1) begin errors++; $display("FAIL full_busy_fall got %0d expected %0d", busy_fall_cyc, done_cyc + 1); end
        checks++; if (rd_count !== 4096) begin errors++; $display("FAIL full_reads got %0d expected 4096", rd_count); end
        checks++; if (rden_double !== 0) begin errors++; $display("FAIL full_rden_width got %0d expected 0", rden_double); end
        bad_hits = addr_oob;
        for (int i = 0; i < 4096; i++) if (hits[i] != 1) bad_hits++;
        checks++; if (bad_hits !== 0) begin errors++; $display("FAIL full_addr_seq bad addresses %0d expected 0", bad_hits); end
    endtask

    task automatic test_checkerboard();
        int lat; bit ok;
        for (int i = 0; i < 4096; i++) mem[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
        exp_byte = 8'hAA;
        clear_mon();
        rand_en = 1'b1;
        do_start(lat);
        wait_done(30000, ok);
        rand_en = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL chk_done_timeout got %b expected 1", ok); end
        checks++; if (hs_count !== 512) begin errors++; $display("FAIL chk_bytes got %0d expected 512", hs_count); end
        checks++; if (byte_bad !== 0) begin errors++; $display("FAIL chk_data bad bytes %0d expected 0", byte_bad); end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL chk_stall_stable got %0d expected 0", stall_viol); end
        checks++; if (stall_seen == 0) begin errors++; $display("FAIL chk_stall_seen got %0d expected >0", stall_seen); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL chk_done_count got %0d expected 1", done_count); end
    endtask

    task automatic test_start_ignored();
        int lat; bit ok; int n; int bad_hits;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        bus.tx_ready = 1'b1;
        exp_byte = 8'h00;
        clear_mon();
        do_start(lat);
        n = 0;
        while (hs_count < 10 && n < 1000) begin @(posedge clk); #1; n++; end
        checks++; if (hs_count !== 10) begin errors++; $display("FAIL ign_reach_byte10 got %0d expected 10", hs_count); end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(20000, ok);
        repeat (3) @(posedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL ign_done_timeout got %b expected 1", ok); end
        checks++; if (hs_count !== 512) begin errors++; $display("FAIL ign_bytes got %0d expected 512", hs_count); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL ign_done_count got %0d expected 1", done_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_idle got %b expected 0", busy); end
        bad_hits = addr_oob;
        for (int i = 0; i < 4096; i++) if (hits[i] != 1) bad_hits++;
        checks++; if (bad_hits !== 0) begin errors++; $display("FAIL ign_addr_seq bad addresses %0d expected 0", bad_hits); end
    endtask

    task automatic test_reset_mid();
        int lat; int n;
        load_first_pattern();
        for (int i = 40; i < 48; i++) mem[i] = 8'hFF;
        bus.tx_ready = 1'b1;
        exp_byte = 8'h00;
        clear_mon();
        do_start(lat);
        n = 0;
        while (hs_count < 5 && n < 1000) begin @(posedge clk); #1; n++; end
        bus.tx_ready = 1'b0;
        n = 0;
        while (!bus.tx_valid && n < 64) begin @(posedge clk); #1; n++; end
        checks++; if (bus.tx_data !== 8'hFF) begin errors++; $display("FAIL rst_byte5_data got %h expected ff", bus.tx_data); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b expected 0", bus.tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b expected 0", busy); end
        @(posedge clk); #1 rst = 1'b0;
        bus.tx_ready = 1'b1;
        clear_mon();
        do_start(lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL restart_latency got %0d expected 16", lat); end
        checks++; if (bus.tx_data !== 8'hAA) begin errors++; $display("FAIL restart_byte0 got %h expected aa", bus.tx_data); end
        checks++; if (first_addr !== 0) begin errors++; $display("FAIL restart_addr got %0d expected 0", first_addr); end
        do_reset();
    endtask

    initial begin
        cyc = 0;
        exp_byte = 8'h00;
        bus.tx_ready = 1'b1;
        start = 1'b0;
        clear_mon();
        test_reset();
        test_first_byte();
        test_full_image();
        test_checkerboard();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
